// File: rtl/power_mode_ctrl_if.sv
// Power-mode type plus the software-request / mode-output bundle between the
// power policy (slave side) and its consumers.
package ptype_pkg;
   typedef enum logic [1:0] {
      SHUTDOWN = 2'd0,
      LP       = 2'd1,
      NORMAL   = 2'd2
   } powermode_t;
endpackage

interface power_mode_ctrl_if;
   import ptype_pkg::*;

   logic       sw_valid;
   powermode_t sw_mode;
   powermode_t p;
   logic       stable;
   logic       mode_change;

   modport master (output sw_valid, sw_mode, input  p, stable, mode_change);
   modport slave  (input  sw_valid, sw_mode, output p, stable, mode_change);
endinterface

// File: rtl/power_mode_ctrl.sv
// Always-on power policy: picks SHUTDOWN/LP/NORMAL for the clock gater and
// sequences each change through a settle window. Optional macro: WAKE_SYNC_EN.
module power_mode_ctrl
   import ptype_pkg::*;
#(
   parameter int IDLE_LP_CYCLES = 16,
   parameter int IDLE_SD_CYCLES = 64,
   parameter int SETTLE_CYCLES  = 4,
   parameter int CNT_W          = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               busy,
   input  logic               wake,
   input  logic               sleep_req,
   power_mode_ctrl_if.slave   pm,
   output logic [CNT_W-1:0]   idle_cnt
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {ACTIVE, LOWP, OFF, SETTLE} state_t;

   state_t             state_q, state_d;
   powermode_t         target_q, target_d;
   powermode_t         p_q, p_d;
   logic               stable_q, stable_d;
   logic               mode_change_q, mode_change_d;
   logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
   logic               pending_wake_q, pending_wake_d;

   logic               wake_i;
   logic               activity;
   logic               idle;
   logic               sw_ok;
   logic               go_settle;
   powermode_t         go_target;

`ifdef WAKE_SYNC_EN
   logic wake_meta_q, wake_sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wake_meta_q <= 1'b0;
         wake_sync_q <= 1'b0;
      end else begin
         wake_meta_q <= wake;
         wake_sync_q <= wake_meta_q;
      end
   end

   assign wake_i = wake_sync_q;
`else
   assign wake_i = wake;
`endif

   assign activity = busy | wake_i;
   assign idle     = ~activity;
   // Unencoded sw_mode values are dropped rather than trusted as a target.
   assign sw_ok    = pm.sw_valid &&
                     (pm.sw_mode == NORMAL || pm.sw_mode == LP || pm.sw_mode == SHUTDOWN);

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_d        = state_q;
      target_d       = target_q;
      p_d            = p_q;
      stable_d       = stable_q;
      mode_change_d  = 1'b0;
      idle_cnt_d     = idle_cnt_q;
      settle_cnt_d   = settle_cnt_q;
      pending_wake_d = pending_wake_q;
      go_settle      = 1'b0;
      go_target      = target_q;

      unique case (state_q)
         ACTIVE, LOWP: begin
            if (activity)                 idle_cnt_d = '0;
            else if (idle_cnt_q != '1)    idle_cnt_d = idle_cnt_q + 1'b1;

            if (state_q == LOWP && activity) begin
               go_settle = 1'b1;
               go_target = NORMAL;
            end else if (sleep_req) begin
               go_settle = 1'b1;
               go_target = SHUTDOWN;
            end else if (sw_ok && pm.sw_mode != p_q) begin
               go_settle = 1'b1;
               go_target = pm.sw_mode;
            end else if (state_q == ACTIVE && idle &&
                         idle_cnt_q == CNT_W'(IDLE_LP_CYCLES - 1)) begin
               go_settle = 1'b1;
               go_target = LP;
            end else if (state_q == LOWP && idle &&
                         idle_cnt_q == CNT_W'(IDLE_SD_CYCLES - 1)) begin
               go_settle = 1'b1;
               go_target = SHUTDOWN;
            end
         end

         OFF: begin
            idle_cnt_d = '0;
            if (wake_i) begin
               go_settle = 1'b1;
               go_target = NORMAL;
            end else if (sw_ok && pm.sw_mode != SHUTDOWN) begin
               go_settle = 1'b1;
               go_target = pm.sw_mode;
            end
         end

         SETTLE: begin
            idle_cnt_d = '0;
            // Activity while heading down is remembered and honoured at completion.
            if (activity && target_q != NORMAL) pending_wake_d = 1'b1;

            if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
               if (pending_wake_d) begin
                  go_settle = 1'b1;
                  go_target = NORMAL;
               end else begin
                  stable_d = 1'b1;
                  unique case (target_q)
                     LP:       state_d = LOWP;
                     SHUTDOWN: state_d = OFF;
                     default:  state_d = ACTIVE;
                  endcase
               end
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end

         default: state_d = ACTIVE;
      endcase

      if (go_settle) begin
         state_d        = SETTLE;
         target_d       = go_target;
         p_d            = go_target;
         stable_d       = 1'b0;
         mode_change_d  = 1'b1;
         idle_cnt_d     = '0;
         settle_cnt_d   = '0;
         pending_wake_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ACTIVE;
         target_q       <= NORMAL;
         p_q            <= NORMAL;
         stable_q       <= 1'b1;
         mode_change_q  <= 1'b0;
         idle_cnt_q     <= '0;
         settle_cnt_q   <= '0;
         pending_wake_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         p_q            <= p_d;
         stable_q       <= stable_d;
         mode_change_q  <= mode_change_d;
         idle_cnt_q     <= idle_cnt_d;
         settle_cnt_q   <= settle_cnt_d;
         pending_wake_q <= pending_wake_d;
      end
   end

   assign pm.p           = p_q;
   assign pm.stable      = stable_q;
   assign pm.mode_change = mode_change_q;
   assign idle_cnt       = idle_cnt_q;

endmodule

// File: doc/power_mode_ctrl.md
Name: power_mode_ctrl

Overview:
- Policy side of the power-mode interface: decides the powermode_t value (SHUTDOWN / LP / NORMAL, from ptype.svh) that drives the clock gater's mode input.
- Tracks idle time, wake events, forced-sleep and software mode requests.
- Sequences every mode change through a settle window so downstream logic knows when the mode is stable.
- Sits in the always-on domain, clocked by the ungated clk.

Parameters:
- IDLE_LP_CYCLES, 16, consecutive idle cycles in NORMAL before moving to LP (>=1).
- IDLE_SD_CYCLES, 64, consecutive idle cycles in LP before moving to SHUTDOWN (>=1).
- SETTLE_CYCLES, 4, cycles p is held with stable=0 after any change (>=1).
- CNT_W, 8, idle counter width. Must satisfy 2^CNT_W-1 >= max(IDLE_LP_CYCLES, IDLE_SD_CYCLES).

Ports:
- clk  input  1  always-on clock
- rst  input  1  reset, asynchronous, active-high
- busy  input  1  core activity; 1 = not idle
- wake  input  1  wake event (external/interrupt)
- sleep_req  input  1  force SHUTDOWN request, level
- sw_valid  input  1  software mode request valid
- sw_mode  input  powermode_t  requested mode
- p  output  powermode_t  current power mode to clock gater
- stable  output  1  1 = mode settled; also sw request ready
- mode_change  output  1  one-cycle pulse, registered with p, on the cycle p takes a new value
- idle_cnt  output  CNT_W  current idle counter value

Behaviour:
- Reset values (async):
  - state=ACTIVE, p=NORMAL, stable=1, mode_change=0, idle_cnt=0.
  - settle counter=0, pending_wake=0.
  - Reset mid-settle aborts immediately to these values.
- States:
  - ACTIVE: p=NORMAL.
  - LOWP: p=LP.
  - OFF: p=SHUTDOWN.
  - SETTLE: p=target, stable=0. Target register holds NORMAL, LP or SHUTDOWN.
- All outputs are registered.
- Idle counter:
  - In ACTIVE/LOWP, increments when busy=0 and wake=0.
  - Saturates at 2^CNT_W-1.
  - Cleared on busy=1 or wake=1, and on every entry to SETTLE.
  - Held at 0 in OFF and SETTLE.
- Priority in stable states (highest first): wake/busy > sleep_req > sw_valid > idle threshold.
- ACTIVE:
  - sleep_req → SETTLE(SHUTDOWN).
  - Else sw_valid with sw_mode≠NORMAL → SETTLE(sw_mode).
  - Else idle_cnt==IDLE_LP_CYCLES-1 with an idle cycle → SETTLE(LP). p=LP after the IDLE_LP_CYCLES-th consecutive idle edge.
  - busy/wake only clear the counter.
- LOWP:
  - busy or wake → SETTLE(NORMAL).
  - Else sleep_req → SETTLE(SHUTDOWN).
  - Else sw_valid with sw_mode≠LP → SETTLE(sw_mode).
  - Else idle_cnt==IDLE_SD_CYCLES-1 with an idle cycle → SETTLE(SHUTDOWN).
- OFF:
  - wake → SETTLE(NORMAL).
  - busy and sleep_req are ignored.
  - sw_valid with sw_mode≠SHUTDOWN → SETTLE(sw_mode).
- sw_valid rules:
  - Sampled only when stable=1.
  - Ignored (dropped, no queuing) while stable=0.
  - sw_mode equal to the current mode is a no-op.
- SETTLE:
  - p updates to target on the entry edge; mode_change=1 for that single cycle.
  - The settle counter runs SETTLE_CYCLES cycles, then the FSM enters the target's stable state and stable returns to 1.
  - Total stable=0 window = SETTLE_CYCLES cycles.
- Events during SETTLE:
  - With target LP/SHUTDOWN: busy/wake sets pending_wake.
  - At settle completion with pending_wake=1: go directly to SETTLE(NORMAL) instead of the stable state, clear pending_wake, mode_change pulses again. stable stays 0 throughout.
  - With target NORMAL: wake/busy is ignored.
  - sleep_req is ignored during SETTLE.
  - SETTLE is never aborted except by rst.
- sleep_req held high after reaching SHUTDOWN has no further effect.
- A wake coincident with an idle threshold wins: the counter clears and no transition down occurs.

Optional Feature:
- Macro WAKE_SYNC_EN.
- Defined: wake passes through a 2-flop synchronizer (async reset to 0) before use. Wake-to-transition latency grows by 2 cycles.
- Undefined: wake is used directly in next-state logic and must be synchronous to clk.

Test Plan:
- Reset then busy=0 for 16 cycles → p=LP after edge 16, mode_change pulse once, stable=0 for 4 cycles, then 1. Continue idle 64 more cycles → p=SHUTDOWN.
- In OFF, pulse wake 1 cycle (macro off) → p=NORMAL next edge, stable=1 after 4 cycles. Same stimulus with WAKE_SYNC_EN → p=NORMAL 2 cycles later.
- busy=1 on the cycle idle_cnt=15 in ACTIVE → no transition, idle_cnt=0, p stays NORMAL.
- Wake on cycle 2 of SETTLE(LP) → p=LP for 4 cycles, then p=NORMAL with a second mode_change pulse, stable=0 throughout, 1 after 4 more cycles.
- sw_valid=1, sw_mode=SHUTDOWN in ACTIVE with sleep_req=0 → SETTLE(SHUTDOWN). sw_valid with sw_mode=LP during that SETTLE → ignored, final p=SHUTDOWN.
- Assert rst on cycle 2 of SETTLE(SHUTDOWN) → immediately p=NORMAL, stable=1, idle_cnt=0, mode_change=0.
